// File: rtl/dmac_arb_pkg.sv
// Shared types for the DMA burst arbiter: FSM state encoding and ID-width helper.
package dmac_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int STAT_W = 32;

    // A single master still needs a 1-bit id port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmac_rr_picker.sv
// Round-robin search: first requester after last_grant, wrapping at N-1 -> 0.
module dmac_rr_picker
    import dmac_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic           any_req,
    output logic [IDW-1:0] pick
);

    int idx;

    // Walk from farthest to nearest so the nearest requester is written last.
    always_comb begin
        any_req = |req;
        pick    = '0;
        idx     = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % N;
            if (req[idx])
                pick = idx[IDW-1:0];
        end
    end

endmodule

// File: rtl/dmac_burst_arbiter.sv
// Burst-locked round-robin arbiter with a registered destination slot.
// Optional per-master beat counters are built when DMAC_ARB_STATS_EN is defined.
module dmac_burst_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int N_MASTER  = 4,
    parameter int DATA_SIZE = 32,
    localparam int IDW      = id_width(N_MASTER)
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef DMAC_ARB_STATS_EN
    input  logic                          stats_clr_i,
    output logic [STAT_W*N_MASTER-1:0]    stat_beats_o,
`endif
    input  logic [N_MASTER-1:0]           src_valid_i,
    output logic [N_MASTER-1:0]           src_ready_o,
    input  logic [N_MASTER*DATA_SIZE-1:0] src_data_i,
    input  logic [N_MASTER-1:0]           src_last_i,
    output logic                          dst_valid_o,
    input  logic                          dst_ready_i,
    output logic [DATA_SIZE-1:0]          dst_data_o,
    output logic                          dst_last_o,
    output logic [IDW-1:0]                dst_id_o
);

    arb_state_e           state, state_nx;
    logic [IDW-1:0]       grant, grant_nx;
    logic [IDW-1:0]       last_grant, last_grant_nx;
    logic                 any_req;
    logic [IDW-1:0]       pick;
    logic                 slot_free;
    logic                 accept;
    logic [N_MASTER-1:0][DATA_SIZE-1:0] src_data_arr;

    assign src_data_arr = src_data_i;

    dmac_rr_picker #(
        .N   (N_MASTER),
        .IDW (IDW)
    ) u_picker (
        .req        (src_valid_i),
        .last_grant (last_grant),
        .any_req    (any_req),
        .pick       (pick)
    );

    // Slot can take a beat when empty or when it drains this same cycle.
    assign slot_free = !dst_valid_o || dst_ready_i;
    assign accept    = (state == BURST) && src_valid_i[grant] && slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDW'(N_MASTER - 1);
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        src_ready_o   = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    grant_nx = pick;
                    state_nx = BURST;
                end
            end
            BURST: begin
                src_ready_o[grant] = slot_free;
                if (accept && src_last_i[grant]) begin
                    last_grant_nx = grant;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_valid_o <= 1'b0;
            dst_data_o  <= '0;
            dst_last_o  <= 1'b0;
            dst_id_o    <= '0;
        end else if (accept) begin
            dst_valid_o <= 1'b1;
            dst_data_o  <= src_data_arr[grant];
            dst_last_o  <= src_last_i[grant];
            dst_id_o    <= grant;
        end else if (dst_ready_i) begin
            dst_valid_o <= 1'b0;
        end
    end

`ifdef DMAC_ARB_STATS_EN
    for (genvar m = 0; m < N_MASTER; m++) begin : g_stat
        logic [STAT_W-1:0] cnt;

        // Clear wins over a coincident beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (stats_clr_i)
                cnt <= '0;
            else if (accept && grant == IDW'(m))
                cnt <= cnt + 1'b1;
        end

        assign stat_beats_o[m*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_dmac_burst_arbiter.sv
// Directed bench for dmac_burst_arbiter: per-cycle vector table plus burst sequences.
module tb_dmac_burst_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        src_valid_i;
    logic [3:0]        src_ready_o;
    logic [3:0][31:0]  dat;
    logic [127:0]      src_data_i;
    logic [3:0]        src_last_i;
    logic              dst_valid_o;
    logic              dst_ready_i;
    logic [31:0]       dst_data_o;
    logic              dst_last_o;
    logic [1:0]        dst_id_o;
`ifdef DMAC_ARB_STATS_EN
    logic              stats_clr_i;
    logic [127:0]      stat_beats_o;
`endif

    assign src_data_i = dat;

    dmac_burst_arbiter #(.N_MASTER(4), .DATA_SIZE(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef DMAC_ARB_STATS_EN
        .stats_clr_i  (stats_clr_i),
        .stat_beats_o (stat_beats_o),
`endif
        .src_valid_i  (src_valid_i),
        .src_ready_o  (src_ready_o),
        .src_data_i   (src_data_i),
        .src_last_i   (src_last_i),
        .dst_valid_o  (dst_valid_o),
        .dst_ready_i  (dst_ready_i),
        .dst_data_o   (dst_data_o),
        .dst_last_o   (dst_last_o),
        .dst_id_o     (dst_id_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        drdy;
        logic [3:0]  rdy;
        logic        dv;
        logic [1:0]  id;
        logic [31:0] data;
    } vec_t;

    typedef struct packed {
        logic [1:0]  id;
        logic        last;
        logic [31:0] data;
    } beat_t;

    vec_t  tbl [22];
    beat_t q[$];
    beat_t bexp[$];
    int    errors = 0;
    int    checks = 0;

    always @(posedge clk)
        if (rst_n && dst_valid_o && dst_ready_i)
            q.push_back('{dst_id_o, dst_last_o, dst_data_o});

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int m);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            #3;
            hit = src_valid_i[m] && src_ready_o[m];
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL accept_timeout_m%0d: got no accept want accept", m);
        end
    endtask

    task automatic check_queue(input string nm);
        chk({nm, "_count"}, 64'(q.size()), 64'(bexp.size()));
        for (int i = 0; i < bexp.size() && i < q.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), 64'(q[i]), 64'(bexp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // valid, last, drdy | rdy, dv, id, data
        tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 32'h0};
        tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 32'hD0};
        tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 32'h0};
        tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 32'hD1};
        tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b0, 2'd0, 32'h0};
        tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 32'hD2};
        tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b0, 2'd0, 32'h0};
        tbl[8]  = '{4'h1, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 32'hD3};
        tbl[9]  = '{4'h1, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 32'h0};
        tbl[10] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 32'hD0};
        tbl[11] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[12] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[13] = '{4'h1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[14] = '{4'h1, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 32'h0};
        tbl[15] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 32'hD0};
        tbl[16] = '{4'h2, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
        tbl[17] = '{4'h2, 4'h0, 1'b1, 4'h2, 1'b0, 2'd0, 32'h0};
        tbl[18] = '{4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 32'hD1};
        tbl[19] = '{4'h2, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 32'hD1};
        tbl[20] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 32'hD1};
        tbl[21] = '{4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};

        rst_n       = 1'b0;
        src_valid_i = 4'hF;
        src_last_i  = 4'h0;
        dst_ready_i = 1'b1;
        dat         = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
`ifdef DMAC_ARB_STATS_EN
        stats_clr_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dst_valid", 64'(dst_valid_o), 64'd0);
        chk("rst_dst_data",  64'(dst_data_o), 64'd0);
        chk("rst_dst_last",  64'(dst_last_o), 64'd0);
        chk("rst_dst_id",    64'(dst_id_o), 64'd0);
        chk("rst_src_ready", 64'(src_ready_o), 64'd0);
        rst_n = 1'b1;

        // Round-robin order, wrap, idle, and back-to-back beats.
        for (int i = 0; i < 22; i++) begin
            src_valid_i = tbl[i].valid;
            src_last_i  = tbl[i].last;
            dst_ready_i = tbl[i].drdy;
            #3;
            chk($sformatf("t%0d_src_ready", i), 64'(src_ready_o), 64'(tbl[i].rdy));
            chk($sformatf("t%0d_dst_valid", i), 64'(dst_valid_o), 64'(tbl[i].dv));
            if (tbl[i].dv) begin
                chk($sformatf("t%0d_dst_id", i), 64'(dst_id_o), 64'(tbl[i].id));
                chk($sformatf("t%0d_dst_data", i), 64'(dst_data_o), 64'(tbl[i].data));
            end
            tick();
        end

        // Master 2 burst locks out master 1, with a mid-burst bubble.
        q.delete();
        src_valid_i = 4'h2;
        src_last_i  = 4'h2;
        dat[1]      = 32'h11;
        wait_accept(1);
        src_valid_i = 4'h6;
        for (int k = 0; k < 4; k++) begin
            dat[2]        = 32'hA0 + 32'(k);
            src_last_i[2] = (k == 3);
            if (k == 2) begin
                src_valid_i[2] = 1'b0;
                repeat (2) begin
                    #3;
                    chk("bubble_no_rearb", 64'(src_ready_o[1]), 64'd0);
                    tick();
                end
                src_valid_i[2] = 1'b1;
            end
            wait_accept(2);
        end
        src_valid_i[2] = 1'b0;
        wait_accept(1);
        src_valid_i = 4'h0;
        repeat (3) tick();
        bexp.delete();
        bexp.push_back('{2'd1, 1'b1, 32'h11});
        for (int k = 0; k < 4; k++)
            bexp.push_back('{2'd2, (k == 3), 32'hA0 + 32'(k)});
        bexp.push_back('{2'd1, 1'b1, 32'h11});
        check_queue("lock");

        // Destination stall: data holds, source is throttled, nothing lost.
        q.delete();
        dst_ready_i = 1'b0;
        src_valid_i = 4'h8;
        src_last_i  = 4'h0;
        dat[3]      = 32'hB0;
        wait_accept(3);
        dat[3]        = 32'hB1;
        src_last_i[3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("stall%0d_dst_valid", c), 64'(dst_valid_o), 64'd1);
            chk($sformatf("stall%0d_dst_data", c), 64'(dst_data_o), 64'hB0);
            chk($sformatf("stall%0d_src_ready", c), 64'(src_ready_o), 64'd0);
            tick();
        end
        dst_ready_i = 1'b1;
        wait_accept(3);
        src_valid_i = 4'h0;
        repeat (3) tick();
        bexp.delete();
        bexp.push_back('{2'd3, 1'b0, 32'hB0});
        bexp.push_back('{2'd3, 1'b1, 32'hB1});
        check_queue("stall");

        // Reset in the middle of a burst.
        dst_ready_i = 1'b0;
        src_valid_i = 4'h4;
        src_last_i  = 4'h0;
        dat[2]      = 32'hC0;
        wait_accept(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dst_valid", 64'(dst_valid_o), 64'd0);
        chk("midrst_src_ready", 64'(src_ready_o), 64'd0);
        chk("midrst_dst_data",  64'(dst_data_o), 64'd0);
        tick();
        rst_n       = 1'b1;
        src_valid_i = 4'h5;
        src_last_i  = 4'h5;
        dat[0]      = 32'h0C;
        dst_ready_i = 1'b1;
        #3;
        chk("postrst_idle_ready", 64'(src_ready_o), 64'd0);
        tick();
        begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                #3;
                seen = dst_valid_o;
                if (!seen) tick();
            end
            chk("postrst_seen", 64'(seen), 64'd1);
            chk("postrst_id",   64'(dst_id_o), 64'd0);
            chk("postrst_data", 64'(dst_data_o), 64'h0C);
            tick();
        end
        src_valid_i = 4'h0;
        repeat (3) tick();

`ifdef DMAC_ARB_STATS_EN
        // Beat counter for master 1, then clear racing a sixth beat.
        stats_clr_i = 1'b1;
        tick();
        stats_clr_i = 1'b0;
        chk("stat_cleared", 64'(stat_beats_o[63:32]), 64'd0);
        src_valid_i = 4'h2;
        src_last_i  = 4'h2;
        begin
            int  acc;
            bit  hit;
            acc = 0;
            for (int c = 0; c < 40 && acc < 6; c++) begin
                #3;
                hit = src_valid_i[1] && src_ready_o[1];
                if (hit && acc == 5) stats_clr_i = 1'b1;
                tick();
                stats_clr_i = 1'b0;
                if (hit) begin
                    acc++;
                    if (acc == 5) chk("stat_five", 64'(stat_beats_o[63:32]), 64'd5);
                    if (acc == 6) chk("stat_clr_wins", 64'(stat_beats_o[63:32]), 64'd0);
                end
            end
            chk("stat_beats_seen", 64'(acc), 64'd6);
        end
        src_valid_i = 4'h0;
        repeat (3) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmac_burst_arbiter.md
DMAC_BURST_ARBITER -- requirements
Module: dmac_burst_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 4, number of source masters.
REQ-002 SHALL have parameter DATA_SIZE, default 32, data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port src_valid_i  input  1 x N_MASTER  per-master beat valid.
REQ-006 SHALL have port src_ready_o  output  1 x N_MASTER  per-master beat accept.
REQ-007 SHALL have port src_data_i  input  DATA_SIZE x N_MASTER  per-master beat data.
REQ-008 SHALL have port src_last_i  input  1 x N_MASTER  marks final beat of a burst.
REQ-009 SHALL have port dst_valid_o  output  1  registered destination valid.
REQ-010 SHALL have port dst_ready_i  input  1  destination accept.
REQ-011 SHALL have port dst_data_o  output  DATA_SIZE  registered destination data.
REQ-012 SHALL have port dst_last_o  output  1  registered last flag.
REQ-013 SHALL have port dst_id_o  output  clog2(N_MASTER)  index of master that sourced the dst beat.

Function
REQ-014 SHALL implement FSM with states IDLE and BURST.
REQ-015 In IDLE, if any src_valid_i is high, SHALL register grant to the first valid master searching from (last_grant+1) mod N_MASTER, with wrap-around from N_MASTER-1 to 0, and SHALL move to BURST the next cycle.
REQ-016 In IDLE with no src_valid_i high, SHALL stay in IDLE; all src_ready_o SHALL be 0.
REQ-017 In BURST, src_ready_o[grant] SHALL equal (!dst_valid_o || dst_ready_i); every other src_ready_o SHALL be 0.
REQ-018 A source beat is accepted when src_valid_i[grant] && src_ready_o[grant]; the output register SHALL load data, last and grant id on that edge; source-to-destination latency is 1 cycle.
REQ-019 A destination drain and a new load in the same cycle SHALL both occur; sustained throughput SHALL be 1 beat/cycle.
REQ-020 dst_valid_o SHALL clear after a drain with no same-cycle load; dst_data_o, dst_last_o and dst_id_o SHALL hold while dst_valid_o && !dst_ready_i.
REQ-021 Grant SHALL remain locked for the whole burst; a deasserted src_valid_i[grant] mid-burst SHALL produce bubbles, not a re-arbitration.
REQ-022 On acceptance of a beat with src_last_i high, SHALL set last_grant to grant and return to IDLE; IDLE SHALL add 1 arbitration cycle between bursts.
REQ-023 A single-beat burst (last on first beat) SHALL be handled as REQ-022.

Reset
REQ-024 On rst_n low, SHALL asynchronously force state IDLE, grant 0, last_grant N_MASTER-1 (master 0 wins first), dst_valid_o 0, dst_data_o 0, dst_last_o 0, dst_id_o 0, all src_ready_o 0.
REQ-025 Reset mid-burst SHALL discard the burst and any pending dst beat without completion.

Configuration
REQ-026 Macro DMAC_ARB_STATS_EN SHALL control per-master beat statistics.
REQ-027 When DMAC_ARB_STATS_EN is defined, SHALL add input stats_clr_i (1) and output stat_beats_o (32 x N_MASTER); each counter SHALL increment by 1 per accepted source beat of its master, wrap at 2^32, reset to 0, and clear synchronously on stats_clr_i, which takes priority over a same-cycle increment.
REQ-028 When DMAC_ARB_STATS_EN is undefined, the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package dmac_arb_pkg SHALL hold the FSM state enum and the ID-width localparam function.
REQ-030 The round-robin search SHALL be a combinational sub-module dmac_rr_picker (inputs: request vector, last_grant; outputs: any_req, pick index).

Verification
REQ-031 After reset, all 4 masters valid -> grants in order 0,1,2,3,0; dst_id_o follows the same order.
REQ-032 Master 2 sends a 4-beat burst 0xA0..0xA3 while master 1 is valid -> all 4 beats out with dst_id_o=2 before any master-1 beat.
REQ-033 dst_ready_i low for 3 cycles with dst_valid_o high -> dst_data_o stable, src_ready_o[grant]=0, no beat lost or duplicated.
REQ-034 last_grant=3, only master 0 valid -> wrap-around grant to 0.
REQ-035 rst_n asserted mid-burst -> dst_valid_o=0 immediately, state IDLE, next grant goes to master 0.
REQ-036 With DMAC_ARB_STATS_EN defined: 5 beats from master 1 then stats_clr_i coincident with a 6th beat -> stat_beats_o[1] goes 5 then 0.
